// File: rtl/lsi_pkg.sv
// Shared definitions for both ends of the low-speed serial interface.
// Field widths, the frame state set and the stop-bit encoding.
package lsi_pkg;

  localparam int LSI_ADDR_W = 8;
  localparam int LSI_DATA_W = 32;

  // mosi level during the stop bit-cycle: commit a write or request a read
  localparam logic STOP_MOSI_WRITE = 1'b0;
  localparam logic STOP_MOSI_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    STOP,
    RDATA
  } lsi_state_e;

  // Index of the final bit-cycle spent in a frame state.
  function automatic logic [5:0] state_last_bit(input lsi_state_e s);
    case (s)
      ADDR:    state_last_bit = 6'(LSI_ADDR_W - 1);
      WDATA:   state_last_bit = 6'(LSI_DATA_W - 1);
      RDATA:   state_last_bit = 6'(LSI_DATA_W - 1);
      default: state_last_bit = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsi_clkgen.sv
// Serial clock generator: CLK_DIV cycles low then CLK_DIV cycles high per bit-cycle.
// rise_tick/fall_tick flag the clk cycle whose closing edge flips lsi_clk.
module lsi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_in_n,
  input  logic enable,
  input  logic clear,
  output logic lsi_clk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_reg;
  logic       lsi_clk_reg;
  logic       wrap;

  assign wrap      = enable && !clear && (div_cnt_reg == DIV_LAST);
  assign rise_tick = wrap && !lsi_clk_reg;
  assign fall_tick = wrap && lsi_clk_reg;
  assign lsi_clk   = lsi_clk_reg;

  always_ff @(posedge clk) begin
    if (!reset_in_n || clear) begin
      div_cnt_reg <= 8'd0;
      lsi_clk_reg <= 1'b0;
    end else if (enable) begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_reg <= 8'd0;
        lsi_clk_reg <= !lsi_clk_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + 8'd1;
      end
    end
  end

endmodule

// File: rtl/lsi_master.sv
// LSI initiator: serialises register write/read commands onto lsi_clk/mosi/stop
// and collects read data from lsi_miso.
module lsi_master
  import lsi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset_in_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [LSI_ADDR_W-1:0] cmd_addr,
  input  logic [LSI_DATA_W-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [LSI_DATA_W-1:0] rsp_data,
  output logic                  lsi_clk,
  output logic                  lsi_mosi,
  input  logic                  lsi_miso,
  output logic                  lsi_stop
);

  lsi_state_e            state_reg;
  logic [5:0]            bit_cnt_reg;
  logic                  write_reg;
  logic [LSI_ADDR_W-1:0] addr_sr_reg;
  logic [LSI_DATA_W-1:0] data_sr_reg;
  logic [LSI_DATA_W-1:0] rd_sr_reg;
  logic                  cmd_ready_reg;
  logic                  rsp_valid_reg;
  logic [LSI_DATA_W-1:0] rsp_data_reg;
  logic                  mosi_reg;
  logic                  stop_reg;

  logic rise_tick;
  logic fall_tick;
  logic accept;
  logic last_bit;
  logic busy;

  assign busy     = (state_reg != IDLE);
  assign accept   = cmd_valid && cmd_ready_reg;
  assign last_bit = (bit_cnt_reg == state_last_bit(state_reg));

  // The divider is held cleared while idle so every frame starts with a full low half-period.
  lsi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk        (clk),
    .reset_in_n (reset_in_n),
    .enable     (busy),
    .clear      (!busy),
    .lsi_clk    (lsi_clk),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_in_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 6'd0;
      write_reg     <= 1'b0;
      addr_sr_reg   <= '0;
      data_sr_reg   <= '0;
      rd_sr_reg     <= '0;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      mosi_reg      <= 1'b0;
      stop_reg      <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;

      if (rise_tick && state_reg == RDATA) begin
        rd_sr_reg <= {lsi_miso, rd_sr_reg[LSI_DATA_W-1:1]};
      end

      if (state_reg == IDLE) begin
        if (accept) begin
          write_reg     <= cmd_write;
          addr_sr_reg   <= cmd_addr;
          data_sr_reg   <= cmd_data;
          cmd_ready_reg <= 1'b0;
          mosi_reg      <= cmd_addr[0];
          bit_cnt_reg   <= 6'd0;
          state_reg     <= ADDR;
        end
      end else if (fall_tick) begin
        bit_cnt_reg <= last_bit ? 6'd0 : bit_cnt_reg + 6'd1;

        case (state_reg)
          ADDR: begin
            if (!last_bit) begin
              addr_sr_reg <= addr_sr_reg >> 1;
              mosi_reg    <= addr_sr_reg[1];
            end else if (write_reg) begin
              state_reg <= WDATA;
              mosi_reg  <= data_sr_reg[0];
            end else begin
              state_reg <= STOP;
              stop_reg  <= 1'b1;
              mosi_reg  <= STOP_MOSI_READ;
            end
          end
          WDATA: begin
            if (!last_bit) begin
              data_sr_reg <= data_sr_reg >> 1;
              mosi_reg    <= data_sr_reg[1];
            end else begin
              state_reg <= STOP;
              stop_reg  <= 1'b1;
              mosi_reg  <= STOP_MOSI_WRITE;
            end
          end
          STOP: begin
            stop_reg <= 1'b0;
            mosi_reg <= 1'b0;
            if (write_reg) begin
              state_reg     <= IDLE;
              cmd_ready_reg <= 1'b1;
            end else begin
              state_reg <= RDATA;
            end
          end
          RDATA: begin
            // the 32nd miso sample was taken on the preceding rising edge
            if (last_bit) begin
              state_reg     <= IDLE;
              cmd_ready_reg <= 1'b1;
              rsp_valid_reg <= 1'b1;
              rsp_data_reg  <= rd_sr_reg;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign lsi_mosi  = mosi_reg;
  assign lsi_stop  = stop_reg;

endmodule

// File: tb/tb_lsi_master.sv
// Bench for lsi_master: a behavioural responder with an upper-casing register memory
// sits on the serial pins of a CLK_DIV=4 and a CLK_DIV=1 instance.
module tb_lsi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_in_n = 1'b0;
  logic        cmd_valid  = 1'b0;
  logic        cmd_write  = 1'b0;
  logic [7:0]  cmd_addr   = 8'd0;
  logic [31:0] cmd_data   = 32'd0;
  logic        sel        = 1'b0;
  logic        miso       = 1'b0;

  logic        valid4, ready4, rsp_valid4, lclk4, mosi4, stop4;
  logic        valid1, ready1, rsp_valid1, lclk1, mosi1, stop1;
  logic [31:0] rsp_data4, rsp_data1;

  assign valid4 = cmd_valid && !sel;
  assign valid1 = cmd_valid && sel;

  lsi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset_in_n(reset_in_n), .cmd_valid(valid4), .cmd_ready(ready4),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .lsi_clk(lclk4),
    .lsi_mosi(mosi4), .lsi_miso(miso), .lsi_stop(stop4)
  );

  lsi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset_in_n(reset_in_n), .cmd_valid(valid1), .cmd_ready(ready1),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .lsi_clk(lclk1),
    .lsi_mosi(mosi1), .lsi_miso(miso), .lsi_stop(stop1)
  );

  // the responder and the checks follow whichever instance sel picks
  logic        m_clk, m_mosi, m_stop, m_ready, m_rsp_valid;
  logic [31:0] m_rsp_data;
  assign m_clk       = sel ? lclk1 : lclk4;
  assign m_mosi      = sel ? mosi1 : mosi4;
  assign m_stop      = sel ? stop1 : stop4;
  assign m_ready     = sel ? ready1 : ready4;
  assign m_rsp_valid = sel ? rsp_valid1 : rsp_valid4;
  assign m_rsp_data  = sel ? rsp_data1 : rsp_data4;

  int checks = 0;
  int errors = 0;
  int proto_err = 0;

  typedef struct {
    logic        rd;
    logic [7:0]  a;
    logic [31:0] d;
  } frame_t;
  frame_t log_q[$];

  bit [31:0] resp_mem [256];
  bit [31:0] exp_mem  [256];

  function automatic logic [31:0] upcase(input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  c;
    for (int b = 0; b < 4; b++) begin
      c = w[8*b +: 8];
      if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
      r[8*b +: 8] = c;
    end
    return r;
  endfunction

  // Responder: collects mosi bits on rising lsi_clk, decodes frames at the stop bit,
  // and after a read request presents the word on miso, one bit per falling edge.
  int          nb = 0;
  logic [39:0] sh = '0;
  logic        reading = 1'b0;
  logic [31:0] rd_word = '0;
  int          rd_idx = 0;

  always @(m_clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      nb = 0;
      reading = 1'b0;
      rd_idx = 0;
      miso = 1'b0;
    end else if (m_clk === 1'b1) begin
      if (!reading) begin
        if (m_stop) begin
          if (nb == 40 && m_mosi == 1'b0) begin
            resp_mem[sh[7:0]] = sh[39:8];
            log_q.push_back('{rd: 1'b0, a: sh[7:0], d: sh[39:8]});
          end else if (nb == 8 && m_mosi == 1'b1) begin
            log_q.push_back('{rd: 1'b1, a: sh[7:0], d: 32'd0});
            rd_word = upcase(resp_mem[sh[7:0]]);
            rd_idx  = 0;
            reading = 1'b1;
          end else begin
            proto_err++;
          end
          nb = 0;
        end else begin
          if (nb < 40) sh[nb] = m_mosi;
          nb++;
        end
      end
    end else if (m_clk === 1'b0 && reading) begin
      if (rd_idx < 32) begin
        miso = rd_word[rd_idx];
        rd_idx++;
      end else begin
        reading = 1'b0;
        miso = 1'b0;
      end
    end
  end

  // Issue one command from idle and follow it until cmd_ready returns.
  task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         output int lat, output int pulses, output int pulse_at,
                         output logic [31:0] rdata, output int toggles);
    logic prev;
    @(negedge clk);
    cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    prev = m_clk;
    lat = -1; pulses = 0; pulse_at = -1; toggles = 0;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (m_clk !== prev) toggles++;
      prev = m_clk;
      if (m_rsp_valid) begin pulses++; pulse_at = n; end
      if (m_ready) begin lat = n; break; end
    end
    rdata = m_rsp_data;
    @(posedge clk); #1;
    if (m_rsp_valid) pulses++;
  endtask

  task automatic test_reset();
    reset_in_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready4, rsp_valid4, lclk4, mosi4, stop4} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctl4: got ready/rv/clk/mosi/stop=%b want 10000", {ready4, rsp_valid4, lclk4, mosi4, stop4});
    end
    checks++;
    if (rsp_data4 !== 32'd0) begin
      errors++;
      $display("FAIL reset_data4: got %h want 00000000", rsp_data4);
    end
    checks++;
    if ({ready1, rsp_valid1, lclk1, mosi1, stop1} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctl1: got ready/rv/clk/mosi/stop=%b want 10000", {ready1, rsp_valid1, lclk1, mosi1, stop1});
    end
    checks++;
    if (rsp_data1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_data1: got %h want 00000000", rsp_data1);
    end
    @(negedge clk);
    reset_in_n = 1'b1;
    $display("reset: ready=%b lsi=%b%b%b", ready4, lclk4, mosi4, stop4);
  endtask

  task automatic test_single_write();
    int lat, pulses, pulse_at, toggles;
    logic [31:0] rdata;
    frame_t f;
    sel = 1'b0;
    run_cmd(1'b1, 8'h5A, 32'h61626364, lat, pulses, pulse_at, rdata, toggles);
    exp_mem[8'h5A] = 32'h61626364;
    checks++;
    if (lat !== 328) begin errors++; $display("FAIL wr_latency: got %0d want 328", lat); end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL wr_no_rsp: got %0d pulses want 0", pulses); end
    checks++;
    if (log_q.size() == 0) begin
      errors++; $display("FAIL wr_frame: got no frame want write 5a 61626364");
    end else begin
      f = log_q.pop_front();
      if ({f.rd, f.a, f.d} !== {1'b0, 8'h5A, 32'h61626364}) begin
        errors++; $display("FAIL wr_frame: got rd=%b a=%h d=%h want rd=0 a=5a d=61626364", f.rd, f.a, f.d);
      end
    end
    $display("write a=5a d=61626364 lat=%0d", lat);
  endtask

  task automatic test_read_loopback();
    int lat, pulses, pulse_at, toggles;
    logic [31:0] rdata;
    frame_t f;
    sel = 1'b0;
    run_cmd(1'b0, 8'h5A, $urandom, lat, pulses, pulse_at, rdata, toggles);
    checks++;
    if (lat !== 328) begin errors++; $display("FAIL rd_latency: got %0d want 328", lat); end
    checks++;
    if (pulses !== 1 || pulse_at !== 328) begin
      errors++; $display("FAIL rd_pulse: got %0d pulses at %0d want 1 at 328", pulses, pulse_at);
    end
    checks++;
    if (rdata !== 32'h41424344) begin errors++; $display("FAIL rd_data: got %h want 41424344", rdata); end
    checks++;
    if (log_q.size() == 0) begin
      errors++; $display("FAIL rd_frame: got no frame want read 5a");
    end else begin
      f = log_q.pop_front();
      if ({f.rd, f.a} !== {1'b1, 8'h5A}) begin
        errors++; $display("FAIL rd_frame: got rd=%b a=%h want rd=1 a=5a", f.rd, f.a);
      end
    end
    $display("read a=5a d=%h lat=%0d", rdata, lat);
  endtask

  task automatic test_back_to_back();
    int end1, hi_cnt, low_cnt, pulses;
    logic [31:0] got;
    frame_t f;
    sel = 1'b0;
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 8'h01; cmd_data = 32'hDEADBEEF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_write = 1'b0; cmd_data = $urandom;
    end1 = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (m_ready) begin end1 = n; break; end
    end
    checks++;
    if (end1 !== 328) begin errors++; $display("FAIL b2b_first_len: got %0d want 328", end1); end
    hi_cnt = 1; low_cnt = 0;
    for (int n = 0; n < 50; n++) begin
      if (m_clk) break;
      low_cnt++;
      @(posedge clk); #1;
      if (m_ready) hi_cnt++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (hi_cnt !== 1) begin errors++; $display("FAIL b2b_ready_gap: got %0d cycles ready want 1", hi_cnt); end
    checks++;
    if (low_cnt < 4) begin errors++; $display("FAIL b2b_clk_low: got %0d low cycles want >=4", low_cnt); end
    pulses = 0; got = '0;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (m_rsp_valid) begin pulses++; got = m_rsp_data; end
      if (m_ready) break;
    end
    exp_mem[8'h01] = 32'hDEADBEEF;
    checks++;
    if (pulses !== 1 || got !== 32'hDEADBEEF) begin
      errors++; $display("FAIL b2b_read: got %0d pulses data %h want 1 pulse data deadbeef", pulses, got);
    end
    checks++;
    if (log_q.size() < 2) begin
      errors++; $display("FAIL b2b_frames: got %0d frames want 2", log_q.size());
    end else begin
      f = log_q.pop_front();
      if ({f.rd, f.a, f.d} !== {1'b0, 8'h01, 32'hDEADBEEF}) begin
        errors++; $display("FAIL b2b_frames: got rd=%b a=%h d=%h want write 01 deadbeef", f.rd, f.a, f.d);
      end
      f = log_q.pop_front();
      if ({f.rd, f.a} !== {1'b1, 8'h01}) begin
        errors++; $display("FAIL b2b_frames: got rd=%b a=%h want read 01", f.rd, f.a);
      end
    end
    $display("back_to_back write/read a=01 d=%h low=%0d", got, low_cnt);
  endtask

  task automatic test_div1();
    int lat, pulses, pulse_at, toggles;
    logic [31:0] rdata;
    frame_t f;
    sel = 1'b1;
    run_cmd(1'b1, 8'hFF, 32'hFFFFFFFF, lat, pulses, pulse_at, rdata, toggles);
    sel = 1'b0;
    checks++;
    if (lat !== 82) begin errors++; $display("FAIL div1_latency: got %0d want 82", lat); end
    checks++;
    if (toggles !== 82) begin errors++; $display("FAIL div1_toggles: got %0d want 82", toggles); end
    checks++;
    if (log_q.size() == 0) begin
      errors++; $display("FAIL div1_frame: got no frame want write ff ffffffff");
    end else begin
      f = log_q.pop_front();
      if ({f.rd, f.a, f.d} !== {1'b0, 8'hFF, 32'hFFFFFFFF}) begin
        errors++; $display("FAIL div1_frame: got rd=%b a=%h d=%h want write ff ffffffff", f.rd, f.a, f.d);
      end
    end
    $display("div1 write a=ff d=ffffffff lat=%0d toggles=%0d", lat, toggles);
  endtask

  task automatic test_reset_mid_read();
    int lat, pulses, pulse_at, toggles, stray;
    logic [31:0] rdata;
    frame_t f;
    sel = 1'b0;
    @(negedge clk);
    cmd_write = 1'b0; cmd_addr = 8'h5A; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (160) @(posedge clk);
    @(negedge clk);
    reset_in_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ready4, rsp_valid4, lclk4, mosi4, stop4} !== 5'b10000) begin
      errors++; $display("FAIL midrst_ctl: got ready/rv/clk/mosi/stop=%b want 10000", {ready4, rsp_valid4, lclk4, mosi4, stop4});
    end
    checks++;
    if (rsp_data4 !== 32'd0) begin errors++; $display("FAIL midrst_data: got %h want 00000000", rsp_data4); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_in_n = 1'b1;
    stray = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (rsp_valid4) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d pulses want 0", stray); end
    if (log_q.size() > 0) f = log_q.pop_front();
    run_cmd(1'b1, 8'h02, 32'h00000007, lat, pulses, pulse_at, rdata, toggles);
    exp_mem[8'h02] = 32'h00000007;
    checks++;
    if (lat !== 328) begin errors++; $display("FAIL midrst_wr_latency: got %0d want 328", lat); end
    checks++;
    if (log_q.size() == 0) begin
      errors++; $display("FAIL midrst_wr_frame: got no frame want write 02 00000007");
    end else begin
      f = log_q.pop_front();
      if ({f.rd, f.a, f.d} !== {1'b0, 8'h02, 32'h00000007}) begin
        errors++; $display("FAIL midrst_wr_frame: got rd=%b a=%h d=%h want write 02 00000007", f.rd, f.a, f.d);
      end
    end
    $display("reset mid-read then write a=02 d=00000007 lat=%0d", lat);
  endtask

  task automatic test_random();
    int lat, pulses, pulse_at, toggles;
    logic [31:0] rdata, d, want;
    logic [7:0] a;
    logic wr;
    frame_t f;
    sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 7));
      d  = $urandom;
      if ($urandom_range(0, 1) == 1) d = {2{8'($urandom_range(8'h60, 8'h7B)), 8'($urandom)}};
      want = upcase(exp_mem[a]);
      run_cmd(wr, a, d, lat, pulses, pulse_at, rdata, toggles);
      checks++;
      if (lat !== 328) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 328", i, lat); end
      checks++;
      if (wr && pulses !== 0) begin
        errors++; $display("FAIL rand_wr_rsp[%0d]: got %0d pulses want 0", i, pulses);
      end else if (!wr && (pulses !== 1 || rdata !== want)) begin
        errors++; $display("FAIL rand_rd[%0d]: got %0d pulses data %h want 1 pulse data %h", i, pulses, rdata, want);
      end
      checks++;
      if (log_q.size() == 0) begin
        errors++; $display("FAIL rand_frame[%0d]: got no frame want rd=%b a=%h", i, !wr, a);
      end else begin
        f = log_q.pop_front();
        if (f.rd !== !wr || f.a !== a || (wr && f.d !== d)) begin
          errors++; $display("FAIL rand_frame[%0d]: got rd=%b a=%h d=%h want rd=%b a=%h d=%h", i, f.rd, f.a, f.d, !wr, a, d);
        end
      end
      if (wr) exp_mem[a] = d;
      $display("rand[%0d] %s a=%h d=%h rsp=%h lat=%0d", i, wr ? "write" : "read", a, d, rdata, lat);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_loopback();
    test_back_to_back();
    test_div1();
    test_reset_mid_read();
    test_random();
    checks++;
    if (proto_err !== 0 || log_q.size() !== 0) begin
      errors++; $display("FAIL protocol: got %0d bad frames %0d unclaimed want 0 0", proto_err, log_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
